// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants and types for the SPI flash sample reader
// Holds the flash READ opcode, address width, FSM state enum and the bit-count
// widths used by the shift engine.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         ADDR_W    = 24;
  localparam int         HDR_BITS  = 32;
  localparam int         BYTE_BITS = 8;
  // Wide enough for the largest "bits remaining" value (HDR_BITS-1).
  localparam int         BIT_CNT_W = $clog2(HDR_BITS);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    GAP
  } state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SCK phase generator, bit counter and MOSI/MISO shifter
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, start_word begin a transaction: 32 header bits taken MSB first from start_word
//   stop              end the transaction; SCK and MOSI return low
//   stall             hold the current phase-0 state (SCK low)
//   miso              flash data, sampled on the edge that ends an SCK-high phase
//   sck, mosi         registered SPI pins
//   hdr_done          combinational: the last header bit completes on this edge
//   byte_done         combinational: a data byte completes on this edge
//   byte_next         the byte completing on this edge (shifter plus live miso)
//   byte_held         the most recently completed byte, valid while stalled
module spi_shift_engine
  import spi_flash_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_word,
  input  logic        stop,
  input  logic        stall,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        hdr_done,
  output logic        byte_done,
  output logic [7:0]  byte_next,
  output logic [7:0]  byte_held
);

  logic                 active;
  logic                 phase;    // 0: SCK low half, 1: SCK high half
  logic                 in_hdr;
  logic [BIT_CNT_W-1:0] bit_cnt;  // bits remaining in the current header/byte, minus one
  // Bit 31 of the header goes straight to mosi at start, so the shifter only needs the
  // remaining 31 bits; during DATA its low byte accumulates miso.
  logic [30:0]          shifter;
  logic                 bit_end;

  assign bit_end   = active && phase && !stall;
  assign hdr_done  = bit_end && in_hdr && (bit_cnt == '0);
  assign byte_done = bit_end && !in_hdr && (bit_cnt == '0);
  assign byte_next = {shifter[6:0], miso};
  assign byte_held = shifter[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      phase   <= 1'b0;
      in_hdr  <= 1'b0;
      bit_cnt <= '0;
      shifter <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else if (stop) begin
      active <= 1'b0;
      phase  <= 1'b0;
      sck    <= 1'b0;
      mosi   <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      phase   <= 1'b0;
      in_hdr  <= 1'b1;
      bit_cnt <= BIT_CNT_W'(HDR_BITS - 1);
      shifter <= start_word[30:0];
      sck     <= 1'b0;
      mosi    <= start_word[31];
    end else if (active && !stall) begin
      if (!phase) begin
        phase <= 1'b1;
        sck   <= 1'b1;
      end else begin
        phase   <= 1'b0;
        sck     <= 1'b0;
        shifter <= {shifter[29:0], miso};
        if (bit_cnt == '0) begin
          in_hdr  <= 1'b0;
          bit_cnt <= BIT_CNT_W'(BYTE_BITS - 1);
          mosi    <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt - BIT_CNT_W'(1);
          // Data phase keeps MOSI low; the flash ignores it after the address.
          mosi    <= in_hdr & shifter[30];
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_sample_reader.sv
// rtl/spi_flash_sample_reader.sv - streams 8-bit samples from SPI flash to a valid/ready sink
// Reads [START_ADDR, START_ADDR+SAMPLE_COUNT) repeatedly with READ (0x03), SPI mode 0.
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   enable                            1 = stream; 0 = end at the next byte boundary
//   spi_clk, spi_cs, spi_mosi         flash pins (SCK = clk/2 while active, CS active low)
//   spi_miso                          flash data, MSB first
//   sample_data, sample_valid         output sample register
//   sample_ready                      sink accepts when valid & ready at a posedge
//   busy                              high whenever the FSM is not IDLE
module spi_flash_sample_reader
  import spi_flash_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR   = 24'h000000,
  parameter logic [ADDR_W-1:0] SAMPLE_COUNT = 24'h010000,
  parameter int                CS_IDLE      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = START_ADDR + SAMPLE_COUNT - ADDR_W'(1);
  localparam int                GAP_W     = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [GAP_W-1:0]  gap_cnt;
  logic              pend;       // a completed byte waits in the shifter for room

  logic              hdr_done;
  logic              byte_done;
  logic [7:0]        byte_next;
  logic [7:0]        byte_held;

  logic              consume;
  logic              load_now;
  logic [7:0]        load_val;
  logic              last_byte;
  logic              end_txn;
  logic              gap_done;
  logic              eng_start;
  logic              eng_stall;

  assign consume   = sample_valid && sample_ready;
  // A byte enters the output register either on the edge it completes (register empty or
  // draining) or later, on the edge that drains the register while the byte is pending.
  assign load_now  = (byte_done && (!sample_valid || sample_ready)) || (pend && sample_ready);
  assign load_val  = pend ? byte_held : byte_next;
  assign last_byte = (addr == LAST_ADDR);
  assign end_txn   = load_now && (last_byte || !enable);
  assign gap_done  = (state == GAP) && (gap_cnt == '0);
  assign eng_start = ((state == IDLE) || gap_done) && enable;
  assign eng_stall = pend && !sample_ready;

  spi_shift_engine u_engine (
    .clk        (clk),
    .rst        (rst),
    .start      (eng_start),
    .start_word ({CMD_READ, addr}),
    .stop       (end_txn),
    .stall      (eng_stall),
    .miso       (spi_miso),
    .sck        (spi_clk),
    .mosi       (spi_mosi),
    .hdr_done   (hdr_done),
    .byte_done  (byte_done),
    .byte_next  (byte_next),
    .byte_held  (byte_held)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      spi_cs       <= 1'b1;
      busy         <= 1'b0;
      addr         <= START_ADDR;
      gap_cnt      <= '0;
      pend         <= 1'b0;
      sample_data  <= 8'h00;
      sample_valid <= 1'b0;
    end else begin
      if (load_now) begin
        sample_data  <= load_val;
        sample_valid <= 1'b1;
        addr         <= last_byte ? START_ADDR : addr + ADDR_W'(1);
      end else if (consume) begin
        sample_valid <= 1'b0;
      end

      if (load_now) begin
        pend <= 1'b0;
      end else if (byte_done) begin
        pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state  <= HDR;
            spi_cs <= 1'b0;
            busy   <= 1'b1;
          end
        end
        HDR: begin
          if (hdr_done) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (end_txn) begin
            state   <= GAP;
            spi_cs  <= 1'b1;
            gap_cnt <= GAP_W'(CS_IDLE - 1);
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (enable) begin
            state  <= HDR;
            spi_cs <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_sample_reader.sv
// tb/tb_spi_flash_sample_reader.sv - self-checking bench with a mode-0 SPI flash model
module tb_spi_flash_sample_reader;

  localparam logic [23:0] START   = 24'h000100;
  localparam logic [23:0] COUNT   = 24'd7;
  localparam int          CS_IDLE = 4;
  localparam logic [23:0] LAST    = START + COUNT - 24'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready = 1'b0;
  logic       busy;

  spi_flash_sample_reader #(
    .START_ADDR   (START),
    .SAMPLE_COUNT (COUNT),
    .CS_IDLE      (CS_IDLE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .spi_clk      (spi_clk),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Flash model: captures command+address on SCK rise, shifts data out on SCK fall.
  // Byte at address a is a[7:0]^0x5A; the address auto-increments inside a transaction.
  int          f_bits = 0;
  logic [31:0] f_cmd = 32'h0;
  logic [31:0] hdr_q[$];

  always @(posedge spi_clk or posedge spi_cs) begin
    if (spi_cs) begin
      f_bits = 0;
    end else begin
      if (f_bits < 32) f_cmd = {f_cmd[30:0], spi_mosi};
      f_bits++;
      if (f_bits == 32) hdr_q.push_back(f_cmd);
    end
  end

  always @(negedge spi_clk) begin
    logic [23:0] a;
    logic [7:0]  b;
    int          idx;
    #1;
    if (!spi_cs && f_bits >= 32) begin
      idx      = f_bits - 32;
      a        = f_cmd[23:0] + 24'(idx / 8);
      b        = a[7:0] ^ 8'h5A;
      spi_miso = b[7 - (idx % 8)];
    end
  end

  int          n_assert = 0;
  int          n_fail = 0;
  int          n_consumed = 0;
  logic [23:0] exp_addr = START;
  logic [7:0]  held = 8'h00;
  logic        held_v = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] last_hdr();
    return (hdr_q.size() > 0) ? hdr_q[hdr_q.size() - 1] : 32'hFFFF_FFFF;
  endfunction

  // One clock: at the falling edge check the byte about to be consumed against the
  // reference address sequence, then advance to just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (held_v && sample_valid) check("held_stable", 32'(sample_data), 32'(held));
    held_v = sample_valid && !sample_ready && !rst;
    held   = sample_data;
    if (sample_valid && sample_ready && !rst) begin
      check("sample", 32'(sample_data), 32'(exp_addr[7:0] ^ 8'h5A));
      exp_addr = (exp_addr == LAST) ? START : exp_addr + 24'd1;
      n_consumed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    exp_addr = START;
    held_v   = 1'b0;
  endtask

  initial begin
    int          cnt;
    int          rises;
    int          n0;
    logic        prev;
    logic [31:0] hdr_exp;

    // Reset state and first-byte timing
    sample_ready = 1'b1;
    enable       = 1'b0;
    do_reset();
    check("rst_cs", 32'(spi_cs), 1);
    check("rst_sck", 32'(spi_clk), 0);
    check("rst_mosi", 32'(spi_mosi), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_data", 32'(sample_data), 0);
    check("rst_busy", 32'(busy), 0);
    hdr_q.delete();
    enable = 1'b1;
    tick();
    check("t1_cs_low", 32'(spi_cs), 0);
    check("t1_busy", 32'(busy), 1);
    check("t1_sck", 32'(spi_clk), 0);
    cnt = 1;
    while (!sample_valid && cnt < 200) begin tick(); cnt++; end
    check("t1_first_valid_cycle", cnt, 81);
    check("t1_first_data", 32'(sample_data), 'h5A);
    check("t1_header", last_hdr(), {8'h03, START});
    cnt = 0;
    while (sample_valid && cnt < 20) begin tick(); cnt++; end
    while (!sample_valid && cnt < 40) begin tick(); cnt++; end
    check("t1_byte_period", cnt, 16);
    check("t1_second_data", 32'(sample_data), 'h5B);

    // Back-pressure stall
    sample_ready = 1'b0;
    do_reset();
    n0  = n_consumed;
    cnt = 0;
    while (!sample_valid && cnt < 200) begin tick(); cnt++; end
    check("t2_first_valid", 32'(sample_valid), 1);
    rises = 0;
    for (int i = 0; i < 100; i++) begin
      prev = spi_clk;
      tick();
      if (i >= 30 && spi_clk && !prev) rises++;
    end
    check("t2_stall_sck_rises", rises, 0);
    check("t2_stall_sck", 32'(spi_clk), 0);
    check("t2_stall_cs", 32'(spi_cs), 0);
    check("t2_held_data", 32'(sample_data), 'h5A);
    sample_ready = 1'b1;
    tick();
    check("t2_nogap_valid", 32'(sample_valid), 1);
    check("t2_nogap_data", 32'(sample_data), 'h5B);
    cnt = 0;
    while (n_consumed < n0 + 3 && cnt < 200) begin tick(); cnt++; end
    check("t2_three_bytes", n_consumed - n0, 3);

    // Window wrap: CS gap then header back at START
    cnt = 0;
    while (!spi_cs && cnt < 300) begin tick(); cnt++; end
    check("t3_cs_rise", 32'(spi_cs), 1);
    cnt = 0;
    while (spi_cs && cnt < 20) begin tick(); cnt++; end
    check("t3_gap_len", cnt, CS_IDLE);
    check("t3_window_bytes", n_consumed - n0, 7);
    cnt = 0;
    while (!sample_valid && cnt < 100) begin tick(); cnt++; end
    check("t3_wrap_data", 32'(sample_data), 'h5A);
    check("t3_wrap_header", last_hdr(), {8'h03, START});

    // enable dropped mid-byte
    cnt = 0;
    while (sample_valid && cnt < 20) begin tick(); cnt++; end
    while (!sample_valid && cnt < 40) begin tick(); cnt++; end
    for (int i = 0; i < 5; i++) tick();
    n0     = n_consumed;
    enable = 1'b0;
    cnt    = 0;
    while (!spi_cs && cnt < 40) begin tick(); cnt++; end
    check("t4_cs_rise", 32'(spi_cs), 1);
    cnt = 0;
    while (busy && cnt < 20) begin tick(); cnt++; end
    check("t4_gap_len", cnt, CS_IDLE);
    for (int i = 0; i < 3; i++) tick();
    check("t4_idle_cs", 32'(spi_cs), 1);
    check("t4_idle_busy", 32'(busy), 0);
    check("t4_inflight_delivered", n_consumed - n0, 1);
    hdr_exp = {8'h03, exp_addr};
    enable  = 1'b1;
    cnt     = 0;
    while (n_consumed < n0 + 2 && cnt < 200) begin tick(); cnt++; end
    check("t4_resume_count", n_consumed - n0, 2);
    check("t4_resume_header", last_hdr(), hdr_exp);

    // Reset during HDR
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    check("t5a_cs", 32'(spi_cs), 1);
    check("t5a_sck", 32'(spi_clk), 0);
    check("t5a_valid", 32'(sample_valid), 0);
    check("t5a_busy", 32'(busy), 0);
    rst      = 1'b0;
    exp_addr = START;
    n0       = n_consumed;
    cnt      = 0;
    while (n_consumed < n0 + 1 && cnt < 200) begin tick(); cnt++; end
    check("t5a_restart_count", n_consumed - n0, 1);
    check("t5a_restart_header", last_hdr(), {8'h03, START});

    // Reset during a DATA stall
    sample_ready = 1'b0;
    cnt = 0;
    while (!sample_valid && cnt < 200) begin tick(); cnt++; end
    for (int i = 0; i < 40; i++) tick();
    check("t5b_stall_sck", 32'(spi_clk), 0);
    check("t5b_stall_cs", 32'(spi_cs), 0);
    rst = 1'b1;
    tick();
    check("t5b_cs", 32'(spi_cs), 1);
    check("t5b_sck", 32'(spi_clk), 0);
    check("t5b_valid", 32'(sample_valid), 0);
    check("t5b_busy", 32'(busy), 0);
    rst          = 1'b0;
    exp_addr     = START;
    held_v       = 1'b0;
    sample_ready = 1'b1;
    n0           = n_consumed;
    cnt          = 0;
    while (n_consumed < n0 + 1 && cnt < 200) begin tick(); cnt++; end
    check("t5b_restart_count", n_consumed - n0, 1);
    check("t5b_restart_header", last_hdr(), {8'h03, START});

    // Random ready over three full windows
    n0  = n_consumed;
    cnt = 0;
    while (n_consumed < n0 + 3 * int'(COUNT) && cnt < 5000) begin
      sample_ready = 1'($urandom_range(0, 1));
      tick();
      cnt++;
    end
    check("t6_random_count", n_consumed - n0, 3 * int'(COUNT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
